// File: rtl/vec_lsu_pkg.sv
// Shared types and helpers for the element-sequential vector load/store unit.
// Used by vec_elem_lsu (optional masking via `VLSU_MASK_EN) and vec_lsu_addr_gen.
package vec_lsu_pkg;

  typedef enum logic [1:0] {
    UNIT        = 2'b00,
    STRIDED     = 2'b01,
    INDEXED     = 2'b10,
    STRIDE_RSVD = 2'b11
  } stride_mode_e;

  typedef enum logic [1:0] {
    SEW8     = 2'b00,
    SEW16    = 2'b01,
    SEW32    = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    REQ,
    WAIT_RSP,
    WB,
    FIN
  } lsu_state_e;

  function automatic logic [2:0] sew_bytes(input sew_e sew);
    case (sew)
      SEW8:    return 3'd1;
      SEW16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] be_lut(input sew_e sew);
    case (sew)
      SEW8:    return 4'b0001;
      SEW16:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] sew_mask(input sew_e sew);
    case (sew)
      SEW8:    return 32'h0000_00FF;
      SEW16:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/vec_lsu_addr_gen.sv
// Combinational per-element address generator: unit, strided or indexed
// addressing (modulo 2^XLEN) plus a SEW-alignment fault flag.
module vec_lsu_addr_gen
  import vec_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VL_W = 7
) (
  input  stride_mode_e      mode_i,
  input  sew_e              sew_i,
  input  logic [XLEN-1:0]   base_i,
  input  logic [XLEN-1:0]   stride_i,
  input  logic [XLEN-1:0]   index_i,
  input  logic [VL_W-1:0]   elem_i,
  output logic [XLEN-1:0]   addr_o,
  output logic              misaligned_o
);

  logic [XLEN-1:0] elem_x;

  always_comb begin
    elem_x = XLEN'(elem_i);
    case (mode_i)
      STRIDED: addr_o = base_i + elem_x * stride_i;
      INDEXED: addr_o = base_i + index_i;
      default: addr_o = base_i + elem_x * XLEN'(sew_bytes(sew_i));
    endcase
  end

  always_comb begin
    case (sew_i)
      SEW16:   misaligned_o = addr_o[0];
      SEW32:   misaligned_o = |addr_o[1:0];
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/vec_elem_lsu.sv
// Element-sequential vector load/store unit; one outstanding request at a time.
// Define VLSU_MASK_EN to add vm/v0_mask inputs for mask-undisturbed element skipping.
module vec_elem_lsu
  import vec_lsu_pkg::*;
#(
  parameter int VLEN   = 512,
  parameter int XLEN   = 32,
  parameter int ELEM_W = 32,
  parameter int VL_W   = $clog2(VLEN/8) + 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                is_load,
  input  logic [1:0]          stride_mode,
  input  logic [1:0]          sew_sel,
  input  logic [XLEN-1:0]     base_addr,
  input  logic [XLEN-1:0]     stride,
  input  logic [VL_W-1:0]     vl,
  input  logic [VLEN-1:0]     index_data,
  input  logic [VLEN-1:0]     store_data,
  input  logic [VLEN-1:0]     vd_old,
`ifdef VLSU_MASK_EN
  input  logic                vm,
  input  logic [VLEN/8-1:0]   v0_mask,
`endif
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [XLEN-1:0]     mem_addr,
  output logic                mem_we,
  output logic [ELEM_W-1:0]   mem_wdata,
  output logic [ELEM_W/8-1:0] mem_be,
  input  logic                mem_rsp_valid,
  input  logic [ELEM_W-1:0]   mem_rsp_data,
  output logic [VLEN-1:0]     vd_data,
  output logic                vd_wr_en,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int OFF_W = $clog2(VLEN) + 1;

  lsu_state_e          state_q, state_d;
  logic [VL_W-1:0]     idx_q, idx_d, vl_q;
  logic                is_load_q;
  stride_mode_e        mode_q;
  sew_e                sew_q;
  logic [XLEN-1:0]     base_q, stride_q;
  logic [VLEN-1:0]     index_q, store_q, vd_q, vd_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [ELEM_W-1:0]   wdata_q, wdata_d;
  logic [ELEM_W/8-1:0] be_q, be_d;
  logic                err_q, err_d, done_q, error_q;
`ifdef VLSU_MASK_EN
  logic                vm_q;
  logic [VLEN/8-1:0]   mask_q;
`endif

  sew_e                   sew_in;
  logic [VL_W-1:0]        vl_max, vl_clamped, idx_inc;
  logic                   launch, last, active, misaligned;
  logic [OFF_W-1:0]       bit_off;
  logic [ELEM_W-1:0]      elem_mask, idx_elem, st_elem;
  logic [VLEN+ELEM_W-1:0] index_ext, store_ext;
  logic [VLEN-1:0]        ins_mask, ins_data;
  logic [XLEN-1:0]        gen_addr;

  assign sew_in = sew_e'(sew_sel);
  assign launch = (state_q == IDLE) && start;

  always_comb begin
    case (sew_in)
      SEW8:    vl_max = VL_W'(VLEN/8);
      SEW16:   vl_max = VL_W'(VLEN/16);
      default: vl_max = VL_W'(VLEN/32);
    endcase
    vl_clamped = (vl > vl_max) ? vl_max : vl;
  end

  // Element slicing: operands are padded so the last element's window stays in range.
  always_comb begin
    bit_off   = OFF_W'(idx_q) * OFF_W'({sew_bytes(sew_q), 3'b000});
    elem_mask = sew_mask(sew_q);
    index_ext = {{ELEM_W{1'b0}}, index_q};
    store_ext = {{ELEM_W{1'b0}}, store_q};
    idx_elem  = index_ext[bit_off +: ELEM_W] & elem_mask;
    st_elem   = store_ext[bit_off +: ELEM_W] & elem_mask;
    ins_mask  = VLEN'(elem_mask) << bit_off;
    ins_data  = VLEN'(mem_rsp_data & elem_mask) << bit_off;
    idx_inc   = idx_q + VL_W'(1);
    last      = (idx_q == vl_q - VL_W'(1));
  end

`ifdef VLSU_MASK_EN
  assign active = vm_q | mask_q[idx_q[VL_W-2:0]];
`else
  assign active = 1'b1;
`endif

  vec_lsu_addr_gen #(
    .XLEN (XLEN),
    .VL_W (VL_W)
  ) u_addr_gen (
    .mode_i       (mode_q),
    .sew_i        (sew_q),
    .base_i       (base_q),
    .stride_i     (stride_q),
    .index_i      (XLEN'(idx_elem)),
    .elem_i       (idx_q),
    .addr_o       (gen_addr),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vl_q      <= '0;
      is_load_q <= 1'b0;
      mode_q    <= UNIT;
      sew_q     <= SEW8;
      base_q    <= '0;
      stride_q  <= '0;
      index_q   <= '0;
      store_q   <= '0;
`ifdef VLSU_MASK_EN
      vm_q      <= 1'b1;
      mask_q    <= '0;
`endif
    end else if (launch) begin
      vl_q      <= vl_clamped;
      is_load_q <= is_load;
      mode_q    <= stride_mode_e'(stride_mode);
      sew_q     <= sew_in;
      base_q    <= base_addr;
      stride_q  <= stride;
      index_q   <= index_data;
      store_q   <= store_data;
`ifdef VLSU_MASK_EN
      vm_q      <= vm;
      mask_q    <= v0_mask;
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vd_q    <= vd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      done_q  <= (state_q == FIN);
      error_q <= (state_q == FIN) && err_q;
    end
  end

  // The request beat is captured on leaving ADDR so it stays stable through REQ.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vd_d    = vd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          err_d   = 1'b0;
          vd_d    = vd_old;
          state_d = (vl == '0) ? FIN : ADDR;
        end
      end
      ADDR: begin
        if (!active) begin
          idx_d = idx_inc;
          if (last) state_d = is_load_q ? WB : FIN;
        end else if (sew_q == SEW_RSVD || misaligned) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          addr_d  = gen_addr;
          wdata_d = st_elem;
          be_d    = be_lut(sew_q);
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          if (is_load_q) begin
            state_d = WAIT_RSP;
          end else begin
            idx_d   = idx_inc;
            state_d = last ? FIN : ADDR;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          vd_d    = (vd_q & ~ins_mask) | ins_data;
          idx_d   = idx_inc;
          state_d = last ? WB : ADDR;
        end
      end
      WB:      state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = (state_q == REQ) && !is_load_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_be        = be_q;
  assign vd_data       = vd_q;
  assign vd_wr_en      = (state_q == WB);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_vec_elem_lsu.sv
// Scoreboard bench for vec_elem_lsu: expected requests are queued at launch and
// popped at each handshake; a byte memory model answers loads one cycle later.
module tb_vec_elem_lsu;

  localparam int VLEN = 512;
  localparam int XLEN = 32;
  localparam int VL_W = 7;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start, is_load;
  logic [1:0]       stride_mode, sew_sel;
  logic [XLEN-1:0]  base_addr, stride;
  logic [VL_W-1:0]  vl;
  logic [VLEN-1:0]  index_data, store_data, vd_old;
`ifdef VLSU_MASK_EN
  logic             vm;
  logic [VLEN/8-1:0] v0_mask;
`endif
  logic             mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [XLEN-1:0]  mem_addr;
  logic [31:0]      mem_wdata, mem_rsp_data;
  logic [3:0]       mem_be;
  logic [VLEN-1:0]  vd_data;
  logic             vd_wr_en, busy, done, error;

  logic [7:0]       mem [0:1023];
  req_t             exp_q[$];
  logic [511:0]     exp_vd, vdold, st, idx;
  int               checks = 0;
  int               errors = 0;
  int               hs_cnt, wr_cnt, stall_at, stall_left;
  bit               hold_rsp, pend;
  logic [31:0]      pend_data;

  always #5 clk = ~clk;

  vec_elem_lsu dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .is_load       (is_load),
    .stride_mode   (stride_mode),
    .sew_sel       (sew_sel),
    .base_addr     (base_addr),
    .stride        (stride),
    .vl            (vl),
    .index_data    (index_data),
    .store_data    (store_data),
    .vd_old        (vd_old),
`ifdef VLSU_MASK_EN
    .vm            (vm),
    .v0_mask       (v0_mask),
`endif
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .vd_data       (vd_data),
    .vd_wr_en      (vd_wr_en),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    logic [9:0] i;
    i = a[9:0];
    return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
  endfunction

  task automatic pushReq(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
    req_t r;
    r.addr = a; r.we = we; r.wdata = wd; r.be = be;
    exp_q.push_back(r);
  endtask

  // One cycle of the memory responder plus the write-back monitor, at the negedge.
  task automatic stepCycle();
    req_t e;
    @(negedge clk);
    mem_rsp_valid = pend;
    mem_rsp_data  = pend ? pend_data : 32'h0;
    pend          = 1'b0;
    mem_req_ready = 1'b1;
    if (mem_req_valid) begin
      if (stall_left > 0 && hs_cnt == stall_at) begin
        mem_req_ready = 1'b0;
        stall_left--;
        if (exp_q.size() > 0) begin
          checkOutput("stall_addr", mem_addr, exp_q[0].addr);
          checkOutput("stall_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (mem_req_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("extra_req", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("req_addr", mem_addr, e.addr);
          checkOutput("req_we", mem_we, e.we);
          checkOutput("req_be", mem_be, e.be);
          if (e.we) checkOutput("req_wdata", mem_wdata, e.wdata);
        end
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[9:0] + 10'(b)] = mem_wdata[8*b +: 8];
        end else if (!hold_rsp) begin
          pend      = 1'b1;
          pend_data = memRead(mem_addr);
        end
      end
    end
    if (vd_wr_en) begin
      wr_cnt++;
      checkOutput("vd_wb_data", vd_data, exp_vd);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [1:0] mode, input logic [1:0] sew,
                               input logic [31:0] base, input logic [31:0] str, input logic [6:0] len,
                               input logic [511:0] ix, input logic [511:0] sd, input logic [511:0] old);
    is_load = ld; stride_mode = mode; sew_sel = sew; base_addr = base; stride = str;
    vl = len; index_data = ix; store_data = sd; vd_old = old;
    hs_cnt = 0; wr_cnt = 0;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("busy_rise", busy, 1);
  endtask

  task automatic waitDone(input logic exp_err, input int exp_wr, input int exp_lat);
    int lat;
    lat = 0;
    for (int c = 1; c <= 300; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      stepCycle();
    end
    if (lat == 0) begin
      checkOutput("done_timeout", done, 1);
    end else begin
      checkOutput("error_flag", error, exp_err);
      checkOutput("busy_fall", busy, 0);
      if (exp_lat > 0) checkOutput("done_latency", lat, exp_lat);
    end
    checkOutput("wr_count", wr_cnt, exp_wr);
    checkOutput("req_left", exp_q.size(), 0);
    exp_q.delete();
    stepCycle();
    checkOutput("done_pulse", done, 0);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; is_load = 1'b0; stride_mode = 2'b00; sew_sel = 2'b00;
    base_addr = '0; stride = '0; vl = '0; index_data = '0; store_data = '0; vd_old = '0;
`ifdef VLSU_MASK_EN
    vm = 1'b1; v0_mask = '0;
`endif
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    hold_rsp = 1'b0; pend = 1'b0; pend_data = '0; stall_at = -1; stall_left = 0;
    hs_cnt = 0; wr_cnt = 0; exp_vd = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h11; mem[10'h104] = 8'h22; mem[10'h108] = 8'h33; mem[10'h10C] = 8'h44;
    for (int i = 0; i < 8; i++) mem[10'h40 + 10'(i)] = 8'hA0 + 8'(i);
    for (int k = 0; k < 16; k++) vdold[32*k +: 32] = $urandom;

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", mem_req_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", {done, error, vd_wr_en, mem_we}, 0);
    checkOutput("rst_vd", vd_data, 0);
    checkOutput("rst_addr", mem_addr, 0);
    n_rst = 1'b1;
    stepCycle();

    $display("[TB] unit load SEW32");
    exp_vd = vdold;
    exp_vd[127:0] = 128'h00000044_00000033_00000022_00000011;
    for (int k = 0; k < 4; k++) pushReq(32'h100 + 32'(4*k), 1'b0, 32'h0, 4'b1111);
    applyStimulus(1'b1, 2'b00, 2'b10, 32'h100, 32'h0, 7'd4, '0, '0, vdold);
    waitDone(1'b0, 1, -1);
    checkOutput("unit_vd", vd_data, exp_vd);

    $display("[TB] strided store SEW16");
    for (int k = 0; k < 16; k++) st[32*k +: 32] = $urandom;
    st[47:0] = 48'hCCCC_BBBB_AAAA;
    pushReq(32'h20, 1'b1, 32'hAAAA, 4'b0011);
    pushReq(32'h1C, 1'b1, 32'hBBBB, 4'b0011);
    pushReq(32'h18, 1'b1, 32'hCCCC, 4'b0011);
    applyStimulus(1'b0, 2'b01, 2'b01, 32'h20, 32'hFFFF_FFFC, 7'd3, '0, st, vdold);
    waitDone(1'b0, 0, -1);
    checkOutput("store_vd_kept", vd_data, vdold);
    checkOutput("store_mem", memRead(32'h18) & 32'hFFFF, 32'hCCCC);

    $display("[TB] indexed load SEW8");
    idx = '0;
    idx[23:0] = 24'h07_00_03;
    exp_vd = vdold;
    exp_vd[23:0] = 24'hA7_A0_A3;
    pushReq(32'h43, 1'b0, 32'h0, 4'b0001);
    pushReq(32'h40, 1'b0, 32'h0, 4'b0001);
    pushReq(32'h47, 1'b0, 32'h0, 4'b0001);
    applyStimulus(1'b1, 2'b10, 2'b00, 32'h40, 32'h0, 7'd3, idx, '0, vdold);
    waitDone(1'b0, 1, -1);
    checkOutput("index_vd", vd_data, exp_vd);

    $display("[TB] back-pressure store SEW32");
    for (int k = 0; k < 16; k++) st[32*k +: 32] = $urandom;
    for (int k = 0; k < 4; k++) pushReq(32'h200 + 32'(4*k), 1'b1, st[32*k +: 32], 4'b1111);
    stall_at = 1; stall_left = 5;
    applyStimulus(1'b0, 2'b00, 2'b10, 32'h200, 32'h0, 7'd4, '0, st, vdold);
    waitDone(1'b0, 0, -1);
    checkOutput("bp_handshakes", hs_cnt, 4);
    checkOutput("bp_stalls_used", stall_left, 0);
    stall_at = -1;

    $display("[TB] misaligned SEW32 load");
    applyStimulus(1'b1, 2'b00, 2'b10, 32'h102, 32'h0, 7'd4, '0, '0, vdold);
    waitDone(1'b1, 0, -1);
    checkOutput("mis_handshakes", hs_cnt, 0);

    $display("[TB] reserved SEW");
    applyStimulus(1'b1, 2'b00, 2'b11, 32'h100, 32'h0, 7'd2, '0, '0, vdold);
    waitDone(1'b1, 0, -1);
    checkOutput("rsvd_handshakes", hs_cnt, 0);

    $display("[TB] vl zero");
    applyStimulus(1'b1, 2'b00, 2'b10, 32'h100, 32'h0, 7'd0, '0, '0, vdold);
    waitDone(1'b0, 0, 2);
    checkOutput("vl0_handshakes", hs_cnt, 0);

    $display("[TB] reset during WAIT_RSP");
    hold_rsp = 1'b1;
    pushReq(32'h100, 1'b0, 32'h0, 4'b1111);
    applyStimulus(1'b1, 2'b00, 2'b10, 32'h100, 32'h0, 7'd4, '0, '0, vdold);
    for (int c = 0; c < 20 && hs_cnt == 0; c++) stepCycle();
    checkOutput("rst_first_hs", hs_cnt, 1);
    stepCycle();
    n_rst = 1'b0;
    stepCycle();
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_valid", mem_req_valid, 0);
    checkOutput("rst_mid_vd", vd_data, 0);
    n_rst = 1'b1;
    hold_rsp = 1'b0;
    pend = 1'b1;
    pend_data = 32'h5555_5555;
    repeat (3) stepCycle();
    checkOutput("late_rsp_vd", vd_data, 0);
    checkOutput("late_rsp_state", {busy, done, mem_req_valid}, 0);
    checkOutput("late_rsp_wr", wr_cnt, 0);
    exp_q.delete();

`ifdef VLSU_MASK_EN
    $display("[TB] masked load SEW32");
    vm = 1'b0;
    v0_mask = '0;
    v0_mask[3:0] = 4'b0101;
    exp_vd = vdold;
    exp_vd[31:0]  = 32'h11;
    exp_vd[95:64] = 32'h33;
    pushReq(32'h100, 1'b0, 32'h0, 4'b1111);
    pushReq(32'h108, 1'b0, 32'h0, 4'b1111);
    applyStimulus(1'b1, 2'b00, 2'b10, 32'h100, 32'h0, 7'd4, '0, '0, vdold);
    waitDone(1'b0, 1, -1);
    checkOutput("mask_vd", vd_data, exp_vd);
    checkOutput("mask_handshakes", hs_cnt, 2);
    vm = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_elem_lsu.md
Name: vec_elem_lsu

Overview:
Parametrised, element-sequential vector load/store unit for the vector co-processor datapath. It supports unit-stride, strided and indexed (unordered-as-ordered) accesses at SEW 8/16/32. It iterates over vl elements with a valid/ready memory request channel and a valid response channel. Loaded elements are packed into a VLEN-wide destination image, which is handed to the vector register file with a single write-enable pulse.

Parameters:
VLEN, 512, vector register width in bits
XLEN, 32, scalar/address width
ELEM_W, 32, memory data width and maximum SEW; must be 32
VL_W, $clog2(VLEN/8)+1, width of vl (fits VLEN/8 elements at SEW 8)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle launch strobe; sampled only in IDLE
is_load  in  1  1 load, 0 store
stride_mode  in  2  00 unit, 01 strided, 10 indexed, 11 reserved (treated as unit)
sew_sel  in  2  00 SEW8, 01 SEW16, 10 SEW32, 11 reserved (error)
base_addr  in  XLEN  rs1 base
stride  in  XLEN  rs2 byte stride, signed
vl  in  VL_W  element count
index_data  in  VLEN  vs2 offsets, SEW-wide, zero-extended
store_data  in  VLEN  vs3 store source
vd_old  in  VLEN  current destination contents
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  byte address
mem_we  out  1  1 store
mem_wdata  out  ELEM_W  element, right-aligned
mem_be  out  ELEM_W/8  byte enables: 0001/0011/1111
mem_rsp_valid  in  1  load data valid
mem_rsp_data  in  ELEM_W  load data, low SEW bits used
vd_data  out  VLEN  assembled destination
vd_wr_en  out  1  one-cycle register-file write strobe
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
error  out  1  one-cycle pulse with done on fault

Behaviour:
- Reset: all outputs 0, vd_data 0, FSM in IDLE, element counter 0. Reset mid-operation abandons any outstanding request; a late mem_rsp_valid after reset is ignored.
- Launch: on start in IDLE, latch all inputs and load vd_data ← vd_old (tail-undisturbed). busy rises the next cycle. start while busy is ignored.
- States: IDLE → ADDR → REQ → (load) WAIT_RSP → ADDR | WB; (store) REQ → ADDR | FIN; WB → FIN; FIN → IDLE.
- ADDR: compute addr_i, modulo 2^XLEN:
  - unit: base + i·(SEW/8)
  - strided: base + i·stride
  - indexed: base + zext(index_data[i·SEW +: SEW])
  - If addr_i is not SEW/8-aligned, or sew_sel=11: go to FIN with error=1, no vd_wr_en, no further requests.
- REQ: mem_req_valid held high with mem_addr, mem_we, mem_wdata and mem_be stable until mem_req_ready. Exactly one outstanding request at a time.
- WAIT_RSP: on mem_rsp_valid, write mem_rsp_data[SEW-1:0] into vd_data[i·SEW +: SEW] and increment i. If i == vl-1 → WB, else → ADDR.
- Store: the element is accepted on the mem_req_valid & mem_req_ready cycle. Last element → FIN. vd_data is never written.
- WB: vd_wr_en = 1 for one cycle, vd_data stable.
- FIN: done = 1 for one cycle; busy drops the same cycle.
- vl = 0: start → FIN directly. done pulses 2 cycles after start; no memory request, no vd_wr_en.
- vl is clamped to VLEN/SEW; elements ≥ vl keep their vd_old value.
- Minimum per-element load latency with ready and response in the same cycle as issue: 3 cycles (ADDR, REQ, WAIT_RSP).

Optional Feature:
VLSU_MASK_EN:
- Defined: adds inputs vm (1) and v0_mask (VLEN/8), sampled at start. When vm=0 and v0_mask[i]=0, element i skips ADDR/REQ entirely (counter advances in one cycle) and its vd_data bits keep vd_old (mask-undisturbed). Masked elements never raise a misalignment error.
- Undefined: ports absent; all elements active.

Decomposition:
- Package vec_lsu_pkg:
  - stride_mode_e (UNIT, STRIDED, INDEXED)
  - sew_e
  - lsu_state_e (IDLE, ADDR, REQ, WAIT_RSP, WB, FIN)
  - function sew_bytes(sew_e)
  - be_lut
- Sub-module vec_lsu_addr_gen: combinational addr_i plus misalignment flag from mode, SEW, base, stride, index element and i.

Test Plan:
- Unit load, SEW32, vl=4, base 0x100, memory words 0x11..0x44, ready always 1, response next cycle → addrs 0x100/104/108/10C; vd_data[127:0]=0x00000044_00000033_00000022_00000011; upper bits = vd_old; one vd_wr_en, then done.
- Strided store, SEW16, stride −4 (0xFFFFFFFC), base 0x20, vl=3, store_data low halves 0xAAAA/0xBBBB/0xCCCC → addrs 0x20/1C/18, mem_be=0011, mem_we=1, no vd_wr_en.
- Indexed load, SEW8, index_data bytes 3,0,7, base 0x40, vl=3 → addrs 0x43/0x40/0x47; bytes packed in order into vd_data[23:0].
- Back-pressure: mem_req_ready low 5 cycles on element 1 → mem_req_valid/addr/wdata stable throughout; exactly 4 handshakes for vl=4.
- Error/corner: SEW32 unit load base 0x102 → done+error, no request, no vd_wr_en. vl=0 → done 2 cycles after start, no request. n_rst pulsed during WAIT_RSP → outputs 0, IDLE, later response ignored.
- VLSU_MASK_EN: vm=0, v0_mask=0b0101, vl=4, SEW32 load → requests only for elements 0 and 2; elements 1 and 3 equal vd_old.
